// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Opcodes, system encodings and hazard-control state encoding
//               for the 5-stage RISC-V core.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam logic [6:0] c_OP     = 7'b0110011;
    localparam logic [6:0] c_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_LOAD   = 7'b0000011;
    localparam logic [6:0] c_STORE  = 7'b0100011;
    localparam logic [6:0] c_BRANCH = 7'b1100011;
    localparam logic [6:0] c_JAL    = 7'b1101111;
    localparam logic [6:0] c_JALR   = 7'b1100111;
    localparam logic [6:0] c_LUI    = 7'b0110111;
    localparam logic [6:0] c_AUIPC  = 7'b0010111;

    localparam logic [31:0] c_ECALL  = 32'h0000_0073;
    localparam logic [31:0] c_EBREAK = 32'h0010_0073;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2,
        ST_HALT     = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl_if
// Description : Pipeline status inputs and sequencing controls of the
//               hazard control unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      id_instr;
    logic             ex_mem_read;
    logic [4:0]       ex_rd;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             resume;
    logic             pc_we;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             exmem_hold;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_instr, ex_mem_read, ex_rd, ex_branch_taken,
               mem_req, mem_ready, resume,
        input  pc_we, ifid_we, ifid_flush, idex_bubble, exmem_hold,
               halted, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_instr, ex_mem_read, ex_rd, ex_branch_taken,
               mem_req, mem_ready, resume,
        output pc_we, ifid_we, ifid_flush, idex_bubble, exmem_hold,
               halted, stall_cnt, flush_cnt
    );
endinterface
`default_nettype wire

// File: rtl/rv_src_decode.sv
`default_nettype none
// ============================================================================
// Module      : rv_src_decode
// Description : Source-register usage decode of an RV32I instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module rv_src_decode
    import riscv_pkg::*;
(
    input  logic [31:0] id_instr,
    output logic        uses_rs1,
    output logic        uses_rs2,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2
);

    assign rs1 = id_instr[19:15];
    assign rs2 = id_instr[24:20];

    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (id_instr[6:0])
            c_OP, c_STORE, c_BRANCH: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            c_OP_IMM, c_LOAD, c_JALR: uses_rs1 = 1'b1;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Stall/flush/bubble sequencing of PC, IF/ID and ID/EX for
//               load-use, redirects, memory wait states and system halts.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    pipe_hazard_ctrl_if.slave      bus
);

    localparam logic [2:0] c_RELOAD = 3'(FLUSH_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_cnt;
    logic [2:0]       w_cnt_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic       w_uses_rs1;
    logic       w_uses_rs2;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic       w_load_use;
    logic       w_mem_stall;
    logic       w_sys;
    logic       w_flush_inc;

    logic w_pc_we;
    logic w_ifid_we;
    logic w_ifid_flush;
    logic w_idex_bubble;
    logic w_exmem_hold;
    logic w_halted;

    rv_src_decode u_src_decode (
        .id_instr (bus.id_instr),
        .uses_rs1 (w_uses_rs1),
        .uses_rs2 (w_uses_rs2),
        .rs1      (w_rs1),
        .rs2      (w_rs2)
    );

    assign w_load_use  = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                         ((w_uses_rs1 && (w_rs1 == bus.ex_rd)) ||
                          (w_uses_rs2 && (w_rs2 == bus.ex_rd)));
    assign w_mem_stall = bus.mem_req && !bus.mem_ready;
    assign w_sys       = (bus.id_instr == c_ECALL) || (bus.id_instr == c_EBREAK);

    always_comb begin
        w_pc_we       = 1'b1;
        w_ifid_we     = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_bubble = 1'b0;
        w_exmem_hold  = 1'b0;
        w_halted      = 1'b0;
        w_flush_inc   = 1'b0;
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;

        case (r_state)
            // MEM_WAIT behaves as RUN: the stall keeps it there, release applies RUN rules
            ST_RUN, ST_MEM_WAIT: begin
                if (w_mem_stall) begin
                    w_pc_we      = 1'b0;
                    w_ifid_we    = 1'b0;
                    w_exmem_hold = 1'b1;
                    w_state_nxt  = ST_MEM_WAIT;
                end else begin
                    w_state_nxt = ST_RUN;
                    if (bus.ex_branch_taken) begin
                        w_ifid_flush  = 1'b1;
                        w_idex_bubble = 1'b1;
                        w_flush_inc   = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            w_state_nxt = ST_FLUSH;
                            w_cnt_nxt   = c_RELOAD;
                        end
                    end else if (w_sys) begin
                        w_pc_we       = 1'b0;
                        w_ifid_we     = 1'b0;
                        w_idex_bubble = 1'b1;
                        w_state_nxt   = ST_HALT;
                    end else if (w_load_use) begin
                        w_pc_we       = 1'b0;
                        w_ifid_we     = 1'b0;
                        w_idex_bubble = 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                if (w_mem_stall) begin
                    w_pc_we      = 1'b0;
                    w_ifid_we    = 1'b0;
                    w_exmem_hold = 1'b1;
                end else begin
                    w_ifid_flush  = 1'b1;
                    w_idex_bubble = 1'b1;
                    if (bus.ex_branch_taken) begin
                        w_flush_inc = 1'b1;
                        w_cnt_nxt   = c_RELOAD;
                    end else begin
                        w_cnt_nxt = (r_cnt != 3'd0) ? r_cnt - 3'd1 : 3'd0;
                        if (r_cnt <= 3'd1) begin
                            w_state_nxt = ST_RUN;
                        end
                    end
                end
            end
            ST_HALT: begin
                w_halted      = 1'b1;
                w_pc_we       = 1'b0;
                w_ifid_we     = 1'b0;
                w_idex_bubble = 1'b1;
                // a pending data access blocks resume and keeps the back end held
                if (w_mem_stall) begin
                    w_exmem_hold = 1'b1;
                end else if (bus.resume) begin
                    w_ifid_flush = 1'b1;
                    w_pc_we      = 1'b1;
                    w_state_nxt  = ST_RUN;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase

        if (!rst) begin
            w_pc_we       = 1'b0;
            w_ifid_we     = 1'b0;
            w_ifid_flush  = 1'b1;
            w_idex_bubble = 1'b1;
            w_exmem_hold  = 1'b0;
            w_halted      = 1'b0;
            w_flush_inc   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_RUN;
            r_cnt       <= 3'd0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (!w_pc_we && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush_inc && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.pc_we       = w_pc_we;
    assign bus.ifid_we     = w_ifid_we;
    assign bus.ifid_flush  = w_ifid_flush;
    assign bus.idex_bubble = w_idex_bubble;
    assign bus.exmem_hold  = w_exmem_hold;
    assign bus.halted      = w_halted;
    assign bus.stall_cnt   = r_stall_cnt;
    assign bus.flush_cnt   = r_flush_cnt;

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline control unit for the 5-stage RISC-V core. It sequences the IF/ID and ID/EX pipeline registers and the PC. It produces stall, flush and bubble controls for load-use hazards, taken branches and jumps, data-memory wait states, and ECALL/EBREAK halts. It sits beside the IF/ID register and observes the instruction held there and the EX/MEM-side status.

## Interface
Parameters:
- FLUSH_CYCLES, 1, cycles IF/ID is flushed after a taken branch/jump (legal 1..4; >1 for registered instruction memory)
- CNT_W, 16, width of the performance counters

Ports:
- clk  input  1  core clock, rising edge
- rst  input  1  asynchronous active-low reset
- id_instr  input  32  instruction currently in IF/ID
- ex_mem_read  input  1  instruction in ID/EX is a load
- ex_rd  input  5  destination register of the ID/EX instruction
- ex_branch_taken  input  1  branch/JAL/JALR in EX redirects the PC this cycle
- mem_req  input  1  MEM stage has an active data-memory access
- mem_ready  input  1  data memory completes the access this cycle
- resume  input  1  leave HALT
- pc_we  output  1  PC update enable
- ifid_we  output  1  IF/ID load enable
- ifid_flush  output  1  IF/ID clears to NOP; overrides ifid_we
- idex_bubble  output  1  ID/EX loads a NOP instead of the decoded instruction
- exmem_hold  output  1  EX/MEM and MEM/WB hold their contents
- halted  output  1  core is in HALT
- stall_cnt  output  CNT_W  cycles with pc_we=0, saturating
- flush_cnt  output  CNT_W  taken-redirect events, saturating

## Operation
- Source-use decode on id_instr[6:0]:
  - R-type, store and branch use rs1 and rs2.
  - OP-IMM, load and JALR use rs1 only.
  - LUI, AUIPC and JAL use no sources.
  - Other opcodes use no sources.
- load_use = ex_mem_read && ex_rd!=0 && a used source register equals ex_rd.
- mem_stall = mem_req && !mem_ready.
- sys = id_instr is 32'h00000073 (ECALL) or 32'h00100073 (EBREAK).
- Default outputs: pc_we=1, ifid_we=1, ifid_flush=0, idex_bubble=0, exmem_hold=0.
- States: RUN, MEM_WAIT, FLUSH, HALT. Priority in RUN: mem_stall > ex_branch_taken > sys > load_use.
- RUN:
  - mem_stall: freeze with pc_we=0, ifid_we=0, exmem_hold=1. Next state MEM_WAIT.
  - ex_branch_taken: ifid_flush=1, idex_bubble=1, flush_cnt+1. Next state FLUSH with cnt=FLUSH_CYCLES-1 when FLUSH_CYCLES>1, otherwise RUN.
  - sys: pc_we=0, ifid_we=0, idex_bubble=1. Next state HALT.
  - load_use: pc_we=0, ifid_we=0, idex_bubble=1. Stays RUN; the hazard clears the next cycle.
- MEM_WAIT:
  - While mem_stall: freeze as above.
  - First cycle with mem_ready=1: apply the RUN rules, excluding mem_stall, and take RUN's next state.
- FLUSH:
  - ifid_flush=1, idex_bubble=1, cnt-1 each cycle. Exit to RUN when cnt reaches 0 after its cycle.
  - mem_stall during FLUSH: freeze, cnt holds, stay in FLUSH.
  - ex_branch_taken during FLUSH reloads cnt=FLUSH_CYCLES-1 and increments flush_cnt.
- HALT:
  - halted=1, pc_we=0, ifid_we=0, idex_bubble=1.
  - resume=1: ifid_flush=1, pc_we=1 (drops the ECALL, fetch continues at PC+4). Next state RUN.
- Counters saturate at all-ones.

## Timing
- Control outputs are combinational from state and inputs, valid within the same cycle. State, cnt and the counters are registered.
- Reset asserted, including mid-operation:
  - Outputs forced to pc_we=0, ifid_we=0, ifid_flush=1, idex_bubble=1, exmem_hold=0, halted=0.
  - State RUN, cnt 0, stall_cnt 0, flush_cnt 0.
- Load-use costs exactly 1 stall cycle. A taken redirect costs FLUSH_CYCLES flushed cycles. Memory wait costs the number of cycles mem_ready is low.
- ex_branch_taken and load_use in the same cycle: the redirect wins; the stalled instruction is flushed.
- Simultaneous resume and mem_stall in HALT: stay in HALT until mem_ready.

## Structure
- riscv_pkg contains:
  - opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC)
  - the ECALL/EBREAK encodings
  - the state enum
- Sub-module rv_src_decode: id_instr -> uses_rs1, uses_rs2, rs1, rs2. It is reused by the forwarding unit.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=5, id_instr=add x6,x5,x7 -> one cycle with pc_we=0, ifid_we=0, idex_bubble=1; stall_cnt=1. Repeating the test with ex_rd=0 -> no stall.
- Taken branch with FLUSH_CYCLES=2: ex_branch_taken pulse -> ifid_flush=1 for 2 consecutive cycles, flush_cnt=1, then defaults.
- Memory wait: mem_req=1, mem_ready low for 3 cycles -> exmem_hold=1, pc_we=0 for exactly 3 cycles; stall_cnt=3.
- ECALL in ID -> halted=1 from the next cycle. resume pulse -> one cycle with ifid_flush=1, pc_we=1, then RUN.
- Priority: mem_stall, ex_branch_taken and load_use all in one cycle -> freeze only. After mem_ready: flush, no stall.
- Reset mid-FLUSH and mid-HALT -> reset output values, counters 0, RUN after release.
